// File: rtl/ext_databus_arb_pkg.sv
// ext_databus_arb_pkg: shared constants, FSM state type and width helper for the databus arbiter
package ext_databus_arb_pkg;

    localparam int IO_ADDR_W    = 32;
    localparam int ARB_STATES_W = 1;

    typedef enum logic [ARB_STATES_W-1:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // counter width for a modulus of n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ext_databus_arb_xrr_pick.sv
// xrr_pick: combinational rotate-priority selector, first request at or after ptr wins
module xrr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 any_o,
    output logic [$clog2(N)-1:0] winner_o
);

    localparam int PW = $clog2(N);

    assign any_o = |req_i;

    // scan from the farthest candidate back toward ptr so the nearest request overrides
    always_comb begin
        winner_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) winner_o = PW'((int'(ptr_i) + k) % N);
        end
    end

endmodule

// File: rtl/ext_databus_arb.sv
// ext_databus_arb: round-robin arbiter merging N engine databus ports onto one memory port
module ext_databus_arb
    import ext_databus_arb_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = IO_ADDR_W,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         m_valid_i,
    input  logic [N_PORTS*ADDR_W-1:0]  m_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]  m_wdata_i,
    input  logic [N_PORTS*DATA_W/8-1:0] m_wstrb_i,
    output logic [N_PORTS-1:0]         m_ready_o,
    output logic [DATA_W-1:0]          m_rdata_o,
    output logic                       mem_valid_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [DATA_W/8-1:0]        mem_wstrb_o,
    input  logic                       mem_ready_i,
    input  logic [DATA_W-1:0]          mem_rdata_i,
    output logic                       busy_o,
    output logic [$clog2(N_PORTS)-1:0] grant_id_o
);

    localparam int GW = $clog2(N_PORTS);
    localparam int BW = cnt_w(MAX_BURST);
    localparam int SW = DATA_W / 8;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d, ptr_q, ptr_d, winner, grant_nxt;
    logic [BW-1:0] beat_q, beat_d;
    logic          any_req, busy, last_beat;

    xrr_pick #(.N(N_PORTS)) u_pick (
        .req_i   (m_valid_i),
        .ptr_i   (ptr_q),
        .any_o   (any_req),
        .winner_o(winner)
    );

    assign busy      = state_q == ARB_BUSY;
    assign grant_nxt = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
    assign last_beat = beat_q == BW'(MAX_BURST - 1);

    // grant on any request in IDLE; release on dropped valid or a completed final burst beat
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        if (!busy) begin
            if (any_req) begin
                state_d = ARB_BUSY;
                grant_d = winner;
                beat_d  = '0;
            end
        end else if (!m_valid_i[grant_q] || (mem_ready_i && last_beat)) begin
            state_d = ARB_IDLE;
            ptr_d   = grant_nxt;
        end else if (mem_ready_i) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // only the granted port sees the memory completion
    always_comb begin
        m_ready_o          = '0;
        m_ready_o[grant_q] = busy & mem_ready_i;
    end

    assign mem_valid_o = busy & m_valid_i[grant_q];
    assign mem_addr_o  = busy ? m_addr_i[grant_q*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata_o = busy ? m_wdata_i[grant_q*DATA_W +: DATA_W] : '0;
    assign mem_wstrb_o = busy ? m_wstrb_i[grant_q*SW +: SW] : '0;
    assign m_rdata_o   = mem_rdata_i;
    assign busy_o      = busy;
    assign grant_id_o  = busy ? grant_q : '0;

    // control registers, cleared asynchronously so a reset abandons any in-flight beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_ext_databus_arb.sv
// tb_ext_databus_arb: directed scenarios against a per-cycle ownership model of the arbiter
module tb_ext_databus_arb;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MB = 4;

    logic            clk = 0, rst = 1;
    logic [NP-1:0]   m_valid = '0;
    logic [NP*AW-1:0] m_addr = '0;
    logic [NP*DW-1:0] m_wdata = '0;
    logic [NP*4-1:0] m_wstrb = '0;
    logic [NP-1:0]   m_ready;
    logic [DW-1:0]   m_rdata, mem_rdata = '0;
    logic            mem_valid, mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            busy;
    logic [1:0]      grant_id;
    logic            mem_en = 0, force_rdy = 0;

    int errors = 0, checks = 0;

    ext_databus_arb #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m_valid_i(m_valid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(m_ready), .m_rdata_o(m_rdata),
        .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;

    // memory stub: acknowledges presented requests when enabled; force_rdy drives ready regardless
    assign mem_ready = force_rdy | (mem_valid & mem_en);
    always @(posedge clk) mem_rdata <= $urandom;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: owner is the granted port (-1 when idle), start is where the next search begins
    int own = -1, start = 0, beats = 0;
    int rdy_cnt[NP] = '{default: 0};
    int run_grant[$], run_beats[$];
    logic prev_busy = 0;

    always @(negedge clk) begin
        bit found;
        if (rst) begin
            own = -1; start = 0; beats = 0;
        end
        if (own >= 0) begin
            chk("mem_valid", mem_valid, m_valid[own]);
            chk("mem_addr", mem_addr, m_addr[own*AW +: AW]);
            chk("mem_wdata", mem_wdata, m_wdata[own*DW +: DW]);
            chk("mem_wstrb", mem_wstrb, m_wstrb[own*4 +: 4]);
            chk("m_ready", m_ready, {3'b0, mem_ready} << own);
            chk("grant_id", grant_id, own);
        end else begin
            chk("mem_valid", mem_valid, 0);
            chk("mem_addr", mem_addr, 0);
            chk("mem_wdata", mem_wdata, 0);
            chk("mem_wstrb", mem_wstrb, 0);
            chk("m_ready", m_ready, 0);
            chk("grant_id", grant_id, 0);
        end
        chk("busy", busy, own >= 0);
        chk("m_rdata", m_rdata, mem_rdata);
        for (int p = 0; p < NP; p++) if (m_ready[p]) rdy_cnt[p]++;
        if (busy && !prev_busy) begin
            run_grant.push_back(grant_id);
            run_beats.push_back(0);
        end
        if (busy && m_ready != 0 && run_beats.size() > 0) run_beats[run_beats.size()-1]++;
        prev_busy = busy;
        if (!rst) begin
            if (own < 0) begin
                found = 0;
                for (int k = 0; k < NP; k++) begin
                    if (!found && m_valid[(start + k) % NP]) begin
                        own = (start + k) % NP; beats = 0; found = 1;
                    end
                end
            end else if (!m_valid[own] || (mem_ready && beats == MB - 1)) begin
                start = (own + 1) % NP; own = -1;
            end else if (mem_ready) begin
                beats++;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic sample;
        @(negedge clk); #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        m_valid[p] = 1'b1;
        m_addr[p*AW +: AW] = a;
        m_wdata[p*DW +: DW] = d;
        m_wstrb[p*4 +: 4] = s;
    endtask

    // serve pending ports, dropping each one after its target beats; beat counts must match exactly
    task automatic run_until(input int t0, input int t1, input int t2, input int t3);
        int tg[NP];
        int base[NP];
        int n;
        tg = '{t0, t1, t2, t3};
        base = rdy_cnt;
        n = 0;
        mem_en = 1;
        while (m_valid != 0 && n < 80) begin
            tick;
            n++;
            for (int p = 0; p < NP; p++)
                if (m_valid[p] && rdy_cnt[p] - base[p] >= tg[p]) m_valid[p] = 1'b0;
        end
        if (m_valid != 0) begin
            errors++; checks++;
            $display("FAIL run_timeout: valid still %b after %0d cycles", m_valid, n);
            m_valid = '0;
        end
        for (int p = 0; p < NP; p++) chk($sformatf("beats_p%0d", p), rdy_cnt[p] - base[p], tg[p]);
        mem_en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1;
        tick; tick;
        sample;
        chk("rst_busy", busy, 0);
        chk("rst_ptr", dut.ptr_q, 0);
        tick;
        rst = 0;

        // single reader, 3 beats, one-cycle arbitration bubble
        b0 = rdy_cnt[0];
        run_grant.delete(); run_beats.delete();
        set_port(0, 16'h0100, 32'h0, 4'h0);
        mem_en = 1;
        sample;
        chk("s1_bubble_mv", mem_valid, 0);
        tick;
        sample;
        chk("s1_first_mv", mem_valid, 1);
        run_until(2, 0, 0, 0);
        chk("s1_total_beats", rdy_cnt[0] - b0, 3);
        chk("s1_runs", run_grant.size(), 1);

        // two ports streaming, bursts of MB beats, alternating grants
        rst = 1; tick; rst = 0;
        run_grant.delete(); run_beats.delete();
        set_port(0, 16'h0400, 32'h0, 4'h0);
        set_port(1, 16'h0500, 32'h0, 4'h0);
        mem_en = 1;
        repeat (20) tick;
        m_valid = '0;
        mem_en = 0;
        tick;
        chk("s2_runs", run_grant.size(), 4);
        for (int i = 0; i < 4 && i < run_grant.size(); i++) begin
            chk($sformatf("s2_grant%0d", i), run_grant[i], i % 2);
            chk($sformatf("s2_beats%0d", i), run_beats[i], 4);
        end
        chk("s2_ptr", dut.ptr_q, 2);

        // ptr=2 with ports 1 and 3 pending: 3 wins first
        run_grant.delete(); run_beats.delete();
        set_port(1, 16'h0310, 32'h0, 4'h0);
        set_port(3, 16'h0330, 32'h0, 4'h0);
        run_until(0, 2, 0, 2);
        tick; tick;
        chk("s3_runs", run_grant.size(), 2);
        if (run_grant.size() == 2) begin
            chk("s3_first", run_grant[0], 3);
            chk("s3_second", run_grant[1], 1);
        end
        chk("s3_ptr", dut.ptr_q, 2);

        // stalled write from port 0 while port 1 waits
        b0 = rdy_cnt[0]; b1 = rdy_cnt[1];
        set_port(0, 16'h0200, 32'hDEADBEEF, 4'hF);
        set_port(1, 16'h0210, 32'h12345678, 4'h3);
        tick;
        for (int i = 0; i < 5; i++) begin
            sample;
            chk("s4_busy", busy, 1);
            chk("s4_grant", grant_id, 0);
            chk("s4_addr", mem_addr, 16'h0200);
            chk("s4_wdata", mem_wdata, 32'hDEADBEEF);
            chk("s4_wstrb", mem_wstrb, 4'hF);
            chk("s4_noready", m_ready, 0);
            tick;
        end
        mem_en = 1;
        sample;
        chk("s4_ready", m_ready, 4'b0001);
        tick;
        m_valid[0] = 1'b0;
        chk("s4_p0_pulses", rdy_cnt[0] - b0, 1);
        chk("s4_p1_pulses", rdy_cnt[1] - b1, 0);
        run_until(0, 1, 0, 0);
        tick; tick;

        // reset mid-burst
        set_port(2, 16'h0220, 32'h0, 4'h0);
        mem_en = 1;
        repeat (3) tick;
        chk("s5_beat_cnt", dut.beat_q, 2);
        rst = 1;
        sample;
        chk("s5_mv", mem_valid, 0);
        chk("s5_busy", busy, 0);
        chk("s5_grant", grant_id, 0);
        chk("s5_ptr", dut.ptr_q, 0);
        m_valid = '0;
        mem_en = 0;
        tick;
        rst = 0;
        tick;

        // granted port drops valid in the same cycle memory completes
        set_port(0, 16'h0600, 32'h0, 4'h0);
        set_port(1, 16'h0610, 32'h0, 4'h0);
        tick;
        m_valid[0] = 1'b0;
        force_rdy = 1;
        sample;
        chk("s6_ack", m_ready, 4'b0001);
        chk("s6_busy", busy, 1);
        tick;
        force_rdy = 0;
        sample;
        chk("s6_idle", busy, 0);
        tick;
        sample;
        chk("s6_regrant_busy", busy, 1);
        chk("s6_regrant_id", grant_id, 1);
        run_until(0, 1, 0, 0);
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_databus_arb.md
# ext_databus_arb

Round-robin arbiter that merges the external-memory databus requests of N `ext_addrgen` engines onto the single native memory port of the Versat external-memory interface. It sits directly downstream of the `ext_addrgen` instances and upstream of the system memory / cache bridge. It grants one engine at a time, holds the grant across back-to-back beats up to a burst limit, then re-arbitrates. Read data is broadcast to all ports; only the granted port sees `m_ready`.

## Interface
Parameters:
- N_PORTS, 2, number of requesting engines (2..8)
- DATA_W, 32, data width
- ADDR_W, `IO_ADDR_W`, address width
- MAX_BURST, 16, max beats per grant before forced re-arbitration (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_valid  in  N_PORTS  per-port request
- m_addr  in  N_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_PORTS*DATA_W  per-port write data
- m_wstrb  in  N_PORTS*DATA_W/8  per-port byte strobes; all-zero means read
- m_ready  out  N_PORTS  per-port completion pulse
- m_rdata  out  DATA_W  read data, broadcast to all ports
- mem_valid  out  1  memory request
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory strobes
- mem_ready  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in BUSY
- grant_id  out  $clog2(N_PORTS)  currently granted port (0 in IDLE)

## Operation
- Registers: state (IDLE/BUSY), grant, ptr (round-robin start index), beat_cnt ($clog2(MAX_BURST), min 1 bit).
- IDLE: mem_valid=0, m_ready=0. If any m_valid is set, the winner is the first set bit searching ptr, ptr+1, … mod N_PORTS. grant←winner, beat_cnt←0, state←BUSY.
- BUSY: mem_valid=m_valid[grant]. mem_addr, mem_wdata and mem_wstrb are muxed from port grant. m_ready[grant]=mem_ready. All other m_ready bits are 0. m_rdata=mem_rdata in every state.
- BUSY, m_valid[grant]=0: state←IDLE, ptr←(grant+1) mod N_PORTS.
- BUSY, mem_ready and beat_cnt=MAX_BURST-1: state←IDLE, ptr←(grant+1) mod N_PORTS.
- BUSY, mem_ready otherwise: beat_cnt←beat_cnt+1, stay in BUSY.
- Upstream obligation: a port holds valid/addr/wdata/wstrb stable until its m_ready. The arbiter does not check this.
- Requests from non-granted ports are ignored and remain pending. No port is lost or starved: worst-case wait is (N_PORTS-1)·(MAX_BURST+1) grant cycles plus memory stalls.

## Timing
- Reset values: state=IDLE, grant=0, ptr=0, beat_cnt=0. All outputs are 0, except m_rdata, which follows mem_rdata.
- Arbitration costs one bubble cycle: a request first seen in IDLE appears on mem_valid the next cycle.
- Streaming within a grant has no bubbles: one beat per cycle while mem_ready stays high.
- mem_* paths from m_* and mem_ready→m_ready are combinational. Only the control registers are clocked.
- m_valid[grant] dropping and mem_ready in the same cycle: the beat completes (m_ready pulses), then the block moves to IDLE.
- MAX_BURST=1: the grant is released after every beat, giving strict alternation when all ports request.
- Only one port requesting: it is re-granted after each one-cycle IDLE bubble.
- rst asserted mid-transfer: everything returns to IDLE immediately. The in-flight memory beat is abandoned; the system reset also resets the memory side.
- ptr wraps from N_PORTS-1 to 0.

## Structure
- Add to `xversat.vh`: `ARB_STATES_W`, `ARB_IDLE`, `ARB_BUSY`. `IO_ADDR_W` is already defined there.
- One sub-module: `xrr_pick`, a combinational rotate-priority selector. Inputs: req[N_PORTS], ptr. Outputs: any, winner. It is reused by future arbiters.
- The top level holds the FSM, counters and the data muxes.

## Test plan
- N=2, port0 reads at 0x100 for 3 beats, mem_ready always 1 → mem_valid rises 1 cycle after request; 3 consecutive m_ready[0] pulses; m_rdata matches mem_rdata each beat.
- N=2, both ports request continuously, MAX_BURST=4 → grant sequence 0,1,0,1, each run exactly 4 beats separated by one idle cycle; grant_id tracks.
- N=4, ports 1 and 3 request with ptr=2 → port 3 is granted first, then port 1 on release; ptr ends at 2.
- Port0 write (wstrb=0xF, wdata=0xDEADBEEF) with mem_ready low for 5 cycles → mem_addr/wdata stable for all 5 cycles; a single m_ready[0] pulse when ready rises; port1 gets no ready.
- rst pulsed while BUSY with beat_cnt=2 → next cycle: state IDLE, mem_valid=0, busy=0, grant_id=0, ptr=0.
- Granted port drops valid with mem_ready high in the same cycle → beat is acknowledged, the block enters IDLE, and the other pending port is granted the following cycle.
